// File: rtl/avsd_sar_adc_ctrl.sv
// SAR ADC controller: track/hold acquisition, then MSB-first binary search on the
// resistor DAC using an external comparator; result delivered over valid/ack.
`timescale 1ns/1ps
module avsd_sar_adc_ctrl #(
  parameter int WIDTH         = 10,
  parameter int SAMPLE_CYCLES = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic             cmp_in,
  output logic             sample_en,
  output logic [WIDTH-1:0] dac_code,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  input  logic             result_ack,
  output logic             overrun
);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int SW = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
  localparam int TW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [WIDTH-1:0] MSB = WIDTH'(1) << (WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT} state_t;

  state_t           state;
  logic [SW-1:0]    samp_cnt;
  logic [TW-1:0]    settle_cnt;
  logic [IW-1:0]    bit_idx;
  logic [WIDTH-1:0] code_next;

  // Decide the current bit from the comparator and raise the next trial bit.
  always_comb begin
    code_next = dac_code;
    for (int i = 0; i < WIDTH; i++) begin
      if (IW'(i) == bit_idx)          code_next[i] = cmp_in;
      else if (IW'(i + 1) == bit_idx) code_next[i] = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state        <= IDLE;
      sample_en    <= 1'b0;
      dac_code     <= '0;
      busy         <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      overrun      <= 1'b0;
      samp_cnt     <= '0;
      settle_cnt   <= '0;
      bit_idx      <= '0;
    end else begin
      overrun <= 1'b0;
      // A completion later in this block overrides the ack clear.
      if (result_ack) result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= SAMPLE;
            sample_en <= 1'b1;
            busy      <= 1'b1;
            samp_cnt  <= SW'(SAMPLE_CYCLES - 1);
          end
        end
        SAMPLE: begin
          if (samp_cnt == '0) begin
            state      <= CONVERT;
            sample_en  <= 1'b0;
            dac_code   <= MSB;
            bit_idx    <= IW'(WIDTH - 1);
            settle_cnt <= TW'(SETTLE_CYCLES);
          end else begin
            samp_cnt <= samp_cnt - SW'(1);
          end
        end
        CONVERT: begin
          if (settle_cnt != '0) begin
            settle_cnt <= settle_cnt - TW'(1);
          end else if (bit_idx != '0) begin
            dac_code   <= code_next;
            bit_idx    <= bit_idx - IW'(1);
            settle_cnt <= TW'(SETTLE_CYCLES);
          end else begin
            result       <= code_next;
            result_valid <= 1'b1;
            overrun      <= result_valid & ~result_ack;
            dac_code     <= '0;
            busy         <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_avsd_sar_adc_ctrl.sv
// Bench for avsd_sar_adc_ctrl: ideal comparator, timeline reference model,
// result scoreboard popped by a monitor on each DUT completion.
`timescale 1ns/1ps
module tb_avsd_sar_adc_ctrl;
  localparam int W   = 10;
  localparam int SC  = 4;
  localparam int ST  = 1;
  localparam int LAT = SC + W * (ST + 1);

  logic         CLK = 1'b0;
  logic         reset, start, cmp_in, sample_en, busy, result_valid, result_ack, overrun;
  logic [W-1:0] dac_code, result;
  int           vin = 0;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;
  int cyc      = 0;

  avsd_sar_adc_ctrl #(.WIDTH(W), .SAMPLE_CYCLES(SC), .SETTLE_CYCLES(ST)) dut (
    .CLK(CLK), .reset(reset), .start(start), .cmp_in(cmp_in),
    .sample_en(sample_en), .dac_code(dac_code), .busy(busy),
    .result(result), .result_valid(result_valid), .result_ack(result_ack),
    .overrun(overrun)
  );

  always #5 CLK = ~CLK;

  // Ideal comparator: VIN >= DAC(code).
  assign cmp_in = (vin >= int'(dac_code));

  // Reference model: a conversion is a fixed-length window after the accepting edge.
  bit m_active = 0, m_rv = 0, m_ovr = 0, m_rst_last = 1, done;
  int m_k = 0, m_vin = 0, m_result = 0;
  int exp_q[$];

  initial forever begin
    @(posedge CLK);
    cyc++;
    m_rst_last = reset;
    m_ovr = 1'b0;
    if (reset) begin
      m_active = 0; m_k = 0; m_rv = 0; m_result = 0;
      exp_q.delete();
    end else begin
      done = 0;
      if (m_active) begin
        m_k++;
        if (m_k == LAT) begin done = 1; m_active = 0; end
      end else if (start) begin
        m_active = 1; m_k = 0; m_vin = vin;
        exp_q.push_back(vin);
      end
      if (done) begin
        m_ovr = m_rv && !result_ack;
        m_rv = 1;
        m_result = m_vin;
      end else if (result_ack) begin
        m_rv = 0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired at cycle %0d", name, cyc);
  endtask

  // Monitor: per-cycle outputs against the model, scoreboard pop on completion.
  bit prev_busy = 0;
  initial forever begin
    int b, e_dac;
    @(negedge CLK);
    e_dac = 0;
    if (m_active && m_k >= SC) begin
      b = (m_k - SC) / (ST + 1);
      e_dac = ((m_vin >> (W - b)) << (W - b)) | (1 << (W - 1 - b));
    end
    check("busy", 32'(busy), 32'(m_active));
    check("sample_en", 32'(sample_en), 32'(m_active && m_k < SC));
    check("dac_code", 32'(dac_code), e_dac);
    check("result_valid", 32'(result_valid), 32'(m_rv));
    check("result", 32'(result), m_result);
    check("overrun", 32'(overrun), 32'(m_ovr));
    if (prev_busy && !busy && !m_rst_last) begin
      n_done++;
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL sb_unexpected: result %0h with nothing expected at cycle %0d", result, cyc);
      end else begin
        check("sb_result", 32'(result), exp_q.pop_front());
      end
    end
    prev_busy = busy;
  end

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (m_active && n < 200) begin step(); n++; end
    if (m_active) fail_now("wait_idle");
  endtask

  // One conversion; optional ack exactly on the completion edge, random acks before.
  task automatic run_conv(input int v, input bit ack_done, input int ack_rate);
    int n = 0;
    wait_idle();
    vin = v; start = 1; step(); start = 0;
    while (m_k != LAT - 1 && n < 200) begin
      result_ack = ($urandom_range(0, 99) < ack_rate);
      step(); n++;
    end
    if (m_k != LAT - 1) fail_now("run_conv");
    result_ack = ack_done; step(); result_ack = 0;
  endtask

  task automatic ack_once();
    result_ack = 1; step(); result_ack = 0;
  endtask

  initial begin
    int d0, v;
    reset = 1; start = 0; result_ack = 0;
    repeat (3) step();
    reset = 0;
    step();

    // Mid-scale code, trial sequence 0x200, 0x300, 0x280, 0x2C0 checked by the monitor.
    run_conv(10'h2A5, 0, 0);
    check("t1_result", 32'(result), 32'h2A5);
    check("t1_valid", 32'(result_valid), 32'h1);
    repeat (3) step();
    ack_once();
    check("t1_ack", 32'(result_valid), 32'h0);

    // Rails.
    run_conv(0, 0, 0);
    check("t2_zero", 32'(result), 32'h0);
    ack_once();
    run_conv(10'h3FF, 0, 0);
    check("t2_full", 32'(result), 32'h3FF);
    ack_once();

    // Overrun: second result lands while first is unacknowledged.
    run_conv(10'h155, 0, 0);
    run_conv(10'h0AA, 0, 0);
    check("t3_ovr_pulse", 32'(overrun), 32'h1);
    check("t3_result", 32'(result), 32'h0AA);
    step();
    check("t3_ovr_single", 32'(overrun), 32'h0);
    ack_once();
    check("t3_ack", 32'(result_valid), 32'h0);

    // Ack on the completion edge: new data wins, no overrun.
    run_conv(10'h155, 0, 0);
    run_conv(10'h0AA, 1, 0);
    check("t4_valid", 32'(result_valid), 32'h1);
    check("t4_ovr", 32'(overrun), 32'h0);
    check("t4_result", 32'(result), 32'h0AA);
    ack_once();

    // Reset at edge 10 with a pending result: everything discarded.
    run_conv(10'h3C1, 0, 0);
    wait_idle();
    vin = 10'h123; start = 1; step(); start = 0;
    while (m_k != 9) step();
    reset = 1; step(); reset = 0;
    check("t5_busy", 32'(busy), 32'h0);
    check("t5_sample_en", 32'(sample_en), 32'h0);
    check("t5_dac", 32'(dac_code), 32'h0);
    check("t5_valid", 32'(result_valid), 32'h0);
    d0 = n_done;
    repeat (40) step();
    check("t5_no_completion", n_done - d0, 0);

    // Start held high: one conversion per LAT+1 cycles.
    wait_idle();
    vin = 10'h1C3; start = 1;
    d0 = n_done;
    for (int i = 0; i < 4 * (LAT + 1); i++) begin
      result_ack = ($urandom_range(0, 3) == 0);
      step();
    end
    start = 0; result_ack = 0;
    step();
    check("t6_held_count", n_done - d0, 4);

    // Start pulses while busy are ignored.
    wait_idle();
    d0 = n_done;
    start = 1; step(); start = 0;
    while (m_active) begin
      start = ($urandom_range(0, 2) == 0);
      step();
    end
    start = 0;
    step();
    check("t6_pulse_count", n_done - d0, 1);

    // Random codes, random acks and gaps.
    for (int i = 0; i < 20; i++) begin
      v = $urandom_range(0, 1023);
      run_conv(v, 1'($urandom_range(0, 1)), 30);
      repeat ($urandom_range(0, 3)) begin
        result_ack = ($urandom_range(0, 1) == 1);
        step();
      end
      result_ack = 0;
    end

    wait_idle();
    repeat (3) step();
    check("sb_empty", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
